// File: rtl/decode_stage_param.sv
// decode_stage_param: parametrised decode stage between fetch and execute.
//   Register file with write-through bypass, 3-source rs forwarding,
//   immediate extension, branch/jump resolution with link capture and a
//   decode/execute pipeline register with stall, flush and valid.
//
// Build option: define DECODE_R0_ZERO_EN to hardwire register 0 to zero
//   (writes to r0 are dropped, reads and bypass of r0 return 0).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall, flush        hold / bubble the pipeline register (flush wins)
//   in_valid            instruction in decode is valid
//   instr               raw instruction, immediate fields in [10:0]
//   rs_addr, rt_addr    source register addresses
//   wr_en/addr/data     writeback port
//   next_pc             PC+1 from fetch
//   fwd_sel, fwd_*      rs forward select (alu/mem/wb/regfile) and values
//   imm_sel, zext8      immediate format select
//   op2_imm             operand 2 takes the immediate
//   branch, cond        conditional branch and condition code
//   jump, jump_reg      unconditional jump, target base = rs
//   target_imm11        branch/jump offset is sext11 (else sext8)
//   link                operand 1 = next_pc (link capture)
//   store_rt_alt        store data read uses rs_addr
//   true_pc, taken      combinational redirect
//   op1_q, op2_q, store_q, link_q, dst_link_q, valid_q   execute-side registers
module decode_stage_param #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int REG_AW   = 3,
  parameter int LINK_REG = NUM_REGS - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [15:0]       instr,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] next_pc,
  input  logic [1:0]        fwd_sel,
  input  logic [DATA_W-1:0] fwd_alu,
  input  logic [DATA_W-1:0] fwd_mem,
  input  logic [DATA_W-1:0] fwd_wb,
  input  logic [1:0]        imm_sel,
  input  logic              zext8,
  input  logic              op2_imm,
  input  logic              branch,
  input  logic [1:0]        cond,
  input  logic              jump,
  input  logic              jump_reg,
  input  logic              target_imm11,
  input  logic              link,
  input  logic              store_rt_alt,
  output logic [DATA_W-1:0] true_pc,
  output logic              taken,
  output logic [DATA_W-1:0] op1_q,
  output logic [DATA_W-1:0] op2_q,
  output logic [DATA_W-1:0] store_q,
  output logic              link_q,
  output logic [REG_AW-1:0] dst_link_q,
  output logic              valid_q
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic              w_wr_eff;
  logic [REG_AW-1:0] w_st_addr;
  logic [DATA_W-1:0] w_rs_rd, w_rt_rd, w_st_rd;
  logic [DATA_W-1:0] w_sext5, w_sext8, w_sext11, w_zext, w_imm;
  logic [DATA_W-1:0] w_op1_pre, w_op1, w_op2;
  logic [DATA_W-1:0] w_base, w_off;
  logic              w_zero, w_neg, w_cond_true;
  logic              w_unused_instr_hi;

  assign w_unused_instr_hi = ^instr[15:11];

`ifdef DECODE_R0_ZERO_EN
  assign w_wr_eff = wr_en && (wr_addr != '0);
`else
  assign w_wr_eff = wr_en;
`endif

  assign w_st_addr = store_rt_alt ? rs_addr : rt_addr;

  // Write-through bypass: a same-cycle write is visible to all three reads.
  // w_wr_eff already excludes r0 when it is hardwired, so r0 is never bypassed.
  always_comb begin
    w_rs_rd = (w_wr_eff && (wr_addr == rs_addr))   ? wr_data : r_regs[rs_addr];
    w_rt_rd = (w_wr_eff && (wr_addr == rt_addr))   ? wr_data : r_regs[rt_addr];
    w_st_rd = (w_wr_eff && (wr_addr == w_st_addr)) ? wr_data : r_regs[w_st_addr];
`ifdef DECODE_R0_ZERO_EN
    if (rs_addr == '0)   w_rs_rd = '0;
    if (rt_addr == '0)   w_rt_rd = '0;
    if (w_st_addr == '0) w_st_rd = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        r_regs[i[REG_AW-1:0]] <= '0;
    end else if (w_wr_eff) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  // Immediates
  assign w_sext5  = {{(DATA_W-5){instr[4]}},   instr[4:0]};
  assign w_sext8  = {{(DATA_W-8){instr[7]}},   instr[7:0]};
  assign w_sext11 = {{(DATA_W-11){instr[10]}}, instr[10:0]};
  assign w_zext   = zext8 ? {{(DATA_W-8){1'b0}}, instr[7:0]}
                          : {{(DATA_W-4){1'b0}}, instr[3:0]};

  always_comb begin
    unique case (imm_sel)
      2'b00:   w_imm = w_sext5;
      2'b01:   w_imm = w_sext8;
      2'b10:   w_imm = w_sext11;
      default: w_imm = w_zext;
    endcase
  end

  // Operands
  always_comb begin
    unique case (fwd_sel)
      2'b00:   w_op1_pre = fwd_alu;
      2'b01:   w_op1_pre = fwd_mem;
      2'b10:   w_op1_pre = fwd_wb;
      default: w_op1_pre = w_rs_rd;
    endcase
  end

  assign w_op1 = link ? next_pc : w_op1_pre;
  assign w_op2 = op2_imm ? w_imm : w_rt_rd;

  // Condition on post-link op1; target base uses pre-link rs value
  assign w_zero = ~|w_op1;
  assign w_neg  = w_op1[DATA_W-1];

  always_comb begin
    unique case (cond)
      2'b00:   w_cond_true = w_zero;
      2'b01:   w_cond_true = ~w_zero;
      2'b10:   w_cond_true = w_neg;
      default: w_cond_true = w_neg | w_zero;
    endcase
  end

  assign w_base  = jump_reg ? w_op1_pre : next_pc;
  assign w_off   = target_imm11 ? w_sext11 : w_sext8;
  assign taken   = in_valid & (jump | (branch & w_cond_true));
  assign true_pc = taken ? (w_base + w_off) : next_pc;

  // Decode/execute register
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      op1_q   <= '0;
      op2_q   <= '0;
      store_q <= '0;
      link_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (!stall) begin
      op1_q   <= w_op1;
      op2_q   <= w_op2;
      store_q <= w_st_rd;
      link_q  <= link;
      valid_q <= in_valid;
    end
  end

  assign dst_link_q = link_q ? REG_AW'(LINK_REG) : '0;

endmodule

// File: tb/tb_decode_stage_param.sv
module tb_decode_stage_param;

  logic        clk = 1'b0;
  logic        rst, stall, flush, in_valid;
  logic [15:0] instr;
  logic [2:0]  rs_addr, rt_addr, wr_addr;
  logic        wr_en;
  logic [15:0] wr_data, next_pc, fwd_alu, fwd_mem, fwd_wb;
  logic [1:0]  fwd_sel, imm_sel, cond;
  logic        zext8, op2_imm, branch, jump, jump_reg, target_imm11, link, store_rt_alt;
  logic [15:0] true_pc, op1_q, op2_q, store_q;
  logic        taken, link_q, valid_q;
  logic [2:0]  dst_link_q;

  always #5 clk = ~clk;

  decode_stage_param #(.DATA_W(16), .NUM_REGS(8), .REG_AW(3), .LINK_REG(7)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .instr(instr), .rs_addr(rs_addr), .rt_addr(rt_addr), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .next_pc(next_pc), .fwd_sel(fwd_sel),
    .fwd_alu(fwd_alu), .fwd_mem(fwd_mem), .fwd_wb(fwd_wb), .imm_sel(imm_sel),
    .zext8(zext8), .op2_imm(op2_imm), .branch(branch), .cond(cond), .jump(jump),
    .jump_reg(jump_reg), .target_imm11(target_imm11), .link(link),
    .store_rt_alt(store_rt_alt), .true_pc(true_pc), .taken(taken),
    .op1_q(op1_q), .op2_q(op2_q), .store_q(store_q), .link_q(link_q),
    .dst_link_q(dst_link_q), .valid_q(valid_q)
  );

`ifdef DECODE_R0_ZERO_EN
  localparam logic [15:0] R0V = 16'h0000;
`else
  localparam logic [15:0] R0V = 16'hFFFF;
`endif

  typedef struct {
    string       tag;
    logic [15:0] op1, op2, st;
    logic        lnk;
    logic [2:0]  dst;
    logic        vld;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 0; stall = 0; flush = 0; in_valid = 0; instr = '0;
    rs_addr = '0; rt_addr = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
    next_pc = '0; fwd_sel = '0; fwd_alu = '0; fwd_mem = '0; fwd_wb = '0;
    imm_sel = '0; zext8 = 0; op2_imm = 0; branch = 0; cond = '0; jump = 0;
    jump_reg = 0; target_imm11 = 0; link = 0; store_rt_alt = 0;
  endtask

  // Check the combinational redirect, queue the registered expectation,
  // then clock once and compare against the popped entry.
  task automatic go(input string tag, input logic e_tk, input logic [15:0] e_pc,
                    input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] es,
                    input logic el, input logic [2:0] ed, input logic ev);
    exp_t e;
    #2;
    chk({tag, ".taken"}, {15'b0, taken}, {15'b0, e_tk});
    chk({tag, ".true_pc"}, true_pc, e_pc);
    e = '{tag: tag, op1: e1, op2: e2, st: es, lnk: el, dst: ed, vld: ev};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s.queue: observed empty expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({e.tag, ".op1_q"},      op1_q,             e.op1);
      chk({e.tag, ".op2_q"},      op2_q,             e.op2);
      chk({e.tag, ".store_q"},    store_q,           e.st);
      chk({e.tag, ".link_q"},     {15'b0, link_q},   {15'b0, e.lnk});
      chk({e.tag, ".dst_link_q"}, {13'b0, dst_link_q}, {13'b0, e.dst});
      chk({e.tag, ".valid_q"},    {15'b0, valid_q},  {15'b0, e.vld});
    end
  endtask

  initial begin
    idle(); rst = 1;
    go("reset", 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 3'd0, 0);

    idle(); wr_en = 1; wr_addr = 3; wr_data = 16'h1234;
    go("wr_r3", 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 3'd0, 0);

    idle(); in_valid = 1; rs_addr = 3; rt_addr = 3; fwd_sel = 2'b11;
    go("rd_r3", 0, 16'h0000, 16'h1234, 16'h1234, 16'h1234, 0, 3'd0, 1);

    idle(); in_valid = 1; wr_en = 1; wr_addr = 5; wr_data = 16'hBEEF;
    rs_addr = 5; rt_addr = 3; store_rt_alt = 1; fwd_sel = 2'b11;
    go("bypass", 0, 16'h0000, 16'hBEEF, 16'h1234, 16'hBEEF, 0, 3'd0, 1);

    idle(); in_valid = 1; branch = 1; cond = 2'b10; fwd_alu = 16'h8000;
    next_pc = 16'h0010; instr = 16'h00FE; imm_sel = 2'b01; op2_imm = 1;
    go("br_neg_t", 1, 16'h000E, 16'h8000, 16'hFFFE, 16'h0000, 0, 3'd0, 1);

    fwd_alu = 16'h0001;
    go("br_neg_nt", 0, 16'h0010, 16'h0001, 16'hFFFE, 16'h0000, 0, 3'd0, 1);

    idle(); in_valid = 1; jump = 1; link = 1; jump_reg = 1; target_imm11 = 1;
    instr = 16'h0004; next_pc = 16'h0021; fwd_sel = 2'b01; fwd_mem = 16'h0100; rt_addr = 5;
    go("jal", 1, 16'h0104, 16'h0021, 16'hBEEF, 16'hBEEF, 1, 3'd7, 1);

    in_valid = 0;
    go("jal_inv", 0, 16'h0021, 16'h0021, 16'hBEEF, 16'hBEEF, 1, 3'd7, 0);

    idle(); in_valid = 1; fwd_alu = 16'h00AA; op2_imm = 1; imm_sel = 2'b11;
    zext8 = 1; instr = 16'h00F3; rt_addr = 3;
    go("load_aa", 0, 16'h0000, 16'h00AA, 16'h00F3, 16'h1234, 0, 3'd0, 1);

    for (int k = 0; k < 3; k++) begin
      idle(); stall = 1; fwd_alu = 16'h5555 + 16'(k); op2_imm = 1; imm_sel = 2'b11;
      instr = 16'h00F3; rt_addr = 5; link = 1;
      wr_en = (k == 1); wr_addr = 2; wr_data = 16'h7777;
      go("stall", 0, 16'h0000, 16'h00AA, 16'h00F3, 16'h1234, 0, 3'd0, 1);
    end

    idle(); stall = 1; flush = 1; in_valid = 1; fwd_alu = 16'h1111; link = 1;
    go("stall_flush", 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 3'd0, 0);

    idle(); in_valid = 1; rs_addr = 2; rt_addr = 2; fwd_sel = 2'b11;
    branch = 1; cond = 2'b00; next_pc = 16'h0030;
    go("rd_r2", 0, 16'h0030, 16'h7777, 16'h7777, 16'h7777, 0, 3'd0, 1);

    idle(); in_valid = 1; fwd_sel = 2'b10; fwd_wb = 16'h0000; branch = 1; cond = 2'b00;
    next_pc = 16'h0040; target_imm11 = 1; instr = 16'h0010; imm_sel = 2'b00;
    op2_imm = 1; rt_addr = 2;
    go("beq_sext5", 1, 16'h0050, 16'h0000, 16'hFFF0, 16'h7777, 0, 3'd0, 1);

    cond = 2'b11; fwd_wb = 16'h0005;
    go("ble_pos", 0, 16'h0040, 16'h0005, 16'hFFF0, 16'h7777, 0, 3'd0, 1);

    idle(); in_valid = 1; jump = 1; next_pc = 16'hFFFF; instr = 16'h0010;
    imm_sel = 2'b10; op2_imm = 1; fwd_sel = 2'b10; fwd_wb = 16'h1111; rt_addr = 2;
    go("jmp_wrap", 1, 16'h000F, 16'h1111, 16'h0010, 16'h7777, 0, 3'd0, 1);

    idle(); in_valid = 1; wr_en = 1; wr_addr = 0; wr_data = 16'hFFFF;
    rs_addr = 0; rt_addr = 0; fwd_sel = 2'b11;
    go("r0_same", 0, 16'h0000, R0V, R0V, R0V, 0, 3'd0, 1);

    idle(); in_valid = 1; rs_addr = 0; rt_addr = 0; fwd_sel = 2'b11;
    go("r0_next", 0, 16'h0000, R0V, R0V, R0V, 0, 3'd0, 1);

    idle(); rst = 1; in_valid = 1; wr_en = 1; wr_addr = 4; wr_data = 16'h4444;
    fwd_alu = 16'h9999; link = 1;
    go("rst_mid", 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 3'd0, 0);

    idle(); in_valid = 1; rs_addr = 3; rt_addr = 4; fwd_sel = 2'b11;
    go("post_rst", 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 3'd0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage_param.md
Name: decode_stage_param

Overview:
Parametrised decode stage for the CPU pipeline, generalised in data width and register count. It contains:
- the register file, with write-through bypass;
- 3-source operand forwarding;
- immediate extension;
- branch and jump resolution with link-register capture;
- a decode/execute pipeline register with stall, flush and a valid bit.

It sits between fetch and execute. The control unit supplies the register addresses and mode selects.

Parameters:
DATA_W, 16, datapath and register width (>=16)
NUM_REGS, 8, register count (power of 2, >=4)
REG_AW, 3, register address width = log2(NUM_REGS)
LINK_REG, NUM_REGS-1, index written by link (jump-and-link) instructions

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall  in  1  hold pipeline register
flush  in  1  insert bubble into pipeline register
in_valid  in  1  instruction in decode is valid
instr  in  16  raw instruction (immediate fields)
rs_addr  in  REG_AW  source-1 address
rt_addr  in  REG_AW  source-2 address
wr_en  in  1  writeback enable
wr_addr  in  REG_AW  writeback address
wr_data  in  DATA_W  writeback data
next_pc  in  DATA_W  PC+1 from fetch
fwd_sel  in  2  rs forward: 00 alu, 01 mem, 10 wb, 11 register file
fwd_alu, fwd_mem, fwd_wb  in  DATA_W each  forwarded values
imm_sel  in  2  00 sext5, 01 sext8, 10 sext11, 11 zext (zext8 selects 8 vs 4 bits)
zext8  in  1  zero-extend width select
op2_imm  in  1  operand 2 = immediate
branch  in  1  conditional branch
cond  in  2  00 ==0, 01 !=0, 10 <0, 11 <=0
jump  in  1  unconditional jump
jump_reg  in  1  target base = rs (else next_pc)
target_imm11  in  1  offset = sext11 (else sext8)
link  in  1  op1 = next_pc
store_rt_alt  in  1  store-data read uses rs_addr instead of rt_addr
true_pc  out  DATA_W  redirect PC (combinational)
taken  out  1  branch/jump taken (combinational)
op1_q, op2_q, store_q  out  DATA_W  registered operands
link_q  out  1  registered link flag
dst_link_q  out  REG_AW  LINK_REG when link_q, else 0
valid_q  out  1  registered valid

Behaviour:
- Register file write: synchronous on clk when wr_en. Reset clears all registers to 0.
- Read bypass: when wr_en and wr_addr matches a read address, the read returns wr_data in the same cycle.
- Store read address: store_rt_alt ? rs_addr : rt_addr.
- Operand 1, pre-link: op1_pre = fwd_sel mux. Code 11 selects the bypassed register-file rs value.
- Operand 1, final: op1 = link ? next_pc : op1_pre.
- Immediates: all sign-extend to DATA_W. zext zero-fills to DATA_W.
- Operand 2: op2 = op2_imm ? imm : rt read.
- Condition: evaluated on op1 (post-link), two's complement.
  - zero = ~|op1; neg = op1[DATA_W-1].
  - cond 11 = neg|zero.
- Target: base = jump_reg ? op1_pre : next_pc; offset = target_imm11 ? sext11 : sext8.
  - Sum is DATA_W bits and wraps modulo 2^DATA_W.
- Redirect:
  - taken = in_valid & (jump | (branch & cond_true)).
  - true_pc = taken ? base+offset : next_pc.
  - Zero-cycle latency.
- Pipeline register update on clk, in priority order:
  1. rst: all *_q = 0.
  2. flush: valid_q = 0, operands = 0, link_q = 0.
  3. stall: all *_q hold.
  4. Otherwise: load op1, op2, store read, link; valid_q = in_valid.
- stall & flush in the same cycle: flush wins.
- Register file writes still occur during stall and flush.
- Reset mid-operation: the pipeline register and register file clear on the next edge. true_pc and taken remain combinational from inputs.
- Latency: operands appear at execute 1 cycle after decode.

Optional Feature:
Macro DECODE_R0_ZERO_EN.
- Defined: register 0 is hardwired to 0.
  - Writes to address 0 are discarded.
  - Reads of address 0 return 0, including the bypass path: wr_data is not bypassed when wr_addr=0.
- Undefined: register 0 is an ordinary register.

Test Plan:
- Reset, then write r3=0x1234: read rs_addr=3, fwd_sel=11, op2_imm=0 -> after one clk, op1_q=0x1234, valid_q=in_valid.
- Same-cycle write r5=0xBEEF and read rs_addr=5 -> op1_q=0xBEEF after the edge (bypass).
- branch=1, cond=10, fwd_sel=00, fwd_alu=0x8000, next_pc=0x0010, instr[7:0]=0xFE, target_imm11=0 -> taken=1, true_pc=0x000E. With fwd_alu=0x0001 -> taken=0, true_pc=0x0010.
- jump=1, link=1, jump_reg=1, rs=0x0100, target_imm11=1, instr[10:0]=0x004, next_pc=0x0021 -> true_pc=0x0104; next clk op1_q=0x0021, link_q=1, dst_link_q=7.
- Load op1_q=0x00AA, then stall=1 with new inputs for 3 cycles -> op1_q stays 0x00AA. Then stall=1 and flush=1 together -> valid_q=0, op1_q=0.
- With DECODE_R0_ZERO_EN: write r0=0xFFFF, read r0 the same and the next cycle -> 0x0000. Without the macro -> 0xFFFF.
